// File: rtl/program_loader.sv
// Framed byte-stream loader for the 16x8 program RAM: hunts for a sync byte,
// writes L payload bytes through the RAM's manual-programming port, then verifies an 8-bit sum.
module program_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       manual_mode,
  output logic       manual_read,
  output logic [3:0] address,
  output logic [7:0] program_switches,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] checksum
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SYNC, S_WAIT_LEN, S_LOAD, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t          r_state, w_next;
  logic [4:0]      r_len, r_index;
  logic [TW-1:0]   r_tmo;
  logic [3:0]      r_addr;
  logic [7:0]      r_data, r_checksum;
  logic            w_accept, w_len_ok, w_timed, w_tmo_hit, w_last;

  assign w_accept  = byte_valid && byte_ready;
  assign w_len_ok  = (byte_data != 8'd0) && (32'(byte_data) <= MAX_LEN);
  assign w_timed   = (r_state == S_WAIT_LEN) || (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_tmo_hit = w_timed && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_last    = (r_index + 5'd1) == r_len;

  assign address          = r_addr;
  assign program_switches = r_data;
  assign checksum         = r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // An accepted byte is tested before the timeout so that it wins a same-edge tie.
  always_comb begin
    w_next      = r_state;
    byte_ready  = 1'b0;
    manual_mode = 1'b0;
    manual_read = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        done  = (r_state == S_DONE);
        error = (r_state == S_ERROR);
        if (start) w_next = S_WAIT_SYNC;
      end
      S_WAIT_SYNC: begin
        byte_ready = 1'b1; manual_mode = 1'b1; busy = 1'b1;
        if (w_accept && (byte_data == SYNC_BYTE)) w_next = S_WAIT_LEN;
      end
      S_WAIT_LEN: begin
        byte_ready = 1'b1; manual_mode = 1'b1; busy = 1'b1;
        if (w_accept)       w_next = w_len_ok ? S_LOAD : S_ERROR;
        else if (w_tmo_hit) w_next = S_ERROR;
      end
      S_LOAD: begin
        byte_ready = 1'b1; manual_mode = 1'b1; busy = 1'b1;
        if (w_accept)       w_next = S_WRITE;
        else if (w_tmo_hit) w_next = S_ERROR;
      end
      S_WRITE: begin
        manual_mode = 1'b1; busy = 1'b1; manual_read = 1'b1;
        w_next = w_last ? S_CHECK : S_LOAD;
      end
      S_CHECK: begin
        byte_ready = 1'b1; manual_mode = 1'b1; busy = 1'b1;
        if (w_accept)       w_next = (byte_data == r_checksum) ? S_DONE : S_ERROR;
        else if (w_tmo_hit) w_next = S_ERROR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_index    <= '0;
      r_tmo      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_checksum <= '0;
    end else begin
      r_tmo <= (w_timed && !w_accept) ? r_tmo + TW'(1) : '0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: if (start) r_checksum <= '0;
        S_WAIT_LEN: if (w_accept && w_len_ok) begin
          r_len   <= byte_data[4:0];
          r_index <= '0;
        end
        S_LOAD: if (w_accept) begin
          r_data     <= byte_data;
          r_addr     <= r_index[3:0];
          r_checksum <= r_checksum + byte_data;
        end
        S_WRITE: r_index <= r_index + 5'd1;
        default: ;
      endcase
    end
  end

endmodule
